// File: rtl/sm_reg_snapshot.sv
// sm_reg_snapshot
//   Periodically scans a CPU register file through its debug read port and
//   keeps a snapshot of every register plus a per-register "changed since the
//   previous scan" flag. A display-side port reads the snapshot.
//
//   Each rising edge of the divided CPU clock requests a scan. Requests
//   arriving while a scan runs (or while frozen) collapse into one pending
//   request that is served once the FSM is back in IDLE and freeze is low.
//
// Ports
//   clkIn      in   1   system clock, all state changes on its rising edge
//   rst_n      in   1   asynchronous active-low reset
//   cpuClk     in   1   divided CPU clock, asynchronous to clkIn
//   freeze     in   1   blocks the start of new scans (never aborts one)
//   regAddr    out  5   debug read address driven to the CPU register file
//   regData    in  32   debug read data, valid SETTLE cycles after regAddr
//   rdAddr     in   5   display-side read address
//   rdData     out 32   snapshot word at rdAddr (registered)
//   rdChanged  out  1   change flag at rdAddr (registered with rdData)
//   busy       out  1   high while a scan is in progress
//   scanDone   out  1   one-cycle pulse when a scan completes
//
// State  | meaning
// IDLE   | waiting for a request (edge or pending) with freeze low
// ADDR   | regAddr = idx, waiting SETTLE cycles for regData to settle
// CAP    | capture regData into snap[idx] and update changed[idx]
// DONE   | scan finished, scanDone pulses, back to IDLE next cycle

module sm_reg_snapshot #(
  parameter int NREGS  = 32,
  parameter int SETTLE = 2
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic        cpuClk,
  input  logic        freeze,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  input  logic [4:0]  rdAddr,
  output logic [31:0] rdData,
  output logic        rdChanged,
  output logic        busy,
  output logic        scanDone
);

  localparam int              AW          = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [4:0]      LAST_IDX    = 5'(NREGS - 1);
  localparam logic [5:0]      NREGS_W     = 6'(NREGS);

  typedef enum logic [1:0] {IDLE, ADDR, CAP, DONE} state_t;

  state_t        state, state_next;
  logic          sync1, sync2, sync_dly;
  logic [1:0]    prime;
  logic          armed;
  logic          cpu_edge;
  logic          pending;
  logic          start;
  logic          enter_addr;
  logic [4:0]    idx;
  logic [CW-1:0] settle_cnt;
  logic [31:0]   snap    [NREGS];
  logic          changed [NREGS];

  // cpuClk synchronizer and edge detector. The reset value of the sync chain
  // is not a real sample, so an edge is only accepted after a genuine low
  // level has been seen (prime marks when sync2 holds a real sample). This
  // keeps a cpuClk that is already high at reset release from looking like
  // a rising edge.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync_dly <= 1'b0;
      prime    <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync1    <= cpuClk;
      sync2    <= sync1;
      sync_dly <= sync2;
      prime    <= {prime[0], 1'b1};
      if (prime[1] && !sync2) armed <= 1'b1;
    end
  end

  assign cpu_edge = sync2 & ~sync_dly & armed;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if ((cpu_edge || pending) && !freeze) begin
          state_next = ADDR;
          start      = 1'b1;
        end
      end
      ADDR: begin
        if (settle_cnt == '0) state_next = CAP;
      end
      CAP: begin
        if (idx < LAST_IDX) state_next = ADDR;
        else                state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_addr = (state_next == ADDR) && (state != ADDR);

  // Control datapath: request flag, scan index, settle timer, status outputs.
  // busy/scanDone are registered from the next state so they line up with
  // the state register.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      idx        <= 5'd0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      scanDone   <= 1'b0;
    end else begin
      // A start consumes both the stored request and any same-cycle edge.
      if (start)         pending <= 1'b0;
      else if (cpu_edge) pending <= 1'b1;

      if (start)                               idx <= 5'd0;
      else if (state == CAP && idx < LAST_IDX) idx <= idx + 5'd1;

      if (enter_addr)                            settle_cnt <= SETTLE_LOAD;
      else if (state == ADDR && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

      busy     <= (state_next == ADDR) || (state_next == CAP);
      scanDone <= (state_next == DONE);
    end
  end

  // idx only moves during a scan, so regAddr naturally holds in IDLE/DONE.
  assign regAddr = idx;

  // Snapshot storage and registered read port. Both use the pre-edge value of
  // snap, so a read of the index being captured returns the old word.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        snap[i]    <= 32'd0;
        changed[i] <= 1'b0;
      end
      rdData    <= 32'd0;
      rdChanged <= 1'b0;
    end else begin
      if (state == CAP) begin
        snap[idx[AW-1:0]]    <= regData;
        changed[idx[AW-1:0]] <= (regData != snap[idx[AW-1:0]]);
      end
      if ({1'b0, rdAddr} < NREGS_W) begin
        rdData    <= snap[rdAddr[AW-1:0]];
        rdChanged <= changed[rdAddr[AW-1:0]];
      end else begin
        rdData    <= 32'd0;
        rdChanged <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_reg_snapshot.sv
module tb_sm_reg_snapshot;

  logic        clk_in    = 1'b0;
  logic        rst_n     = 1'b1;
  logic        cpu_clk   = 1'b0;
  logic        cpu_clk16 = 1'b0;
  logic        freeze    = 1'b0;
  logic [4:0]  rd_addr   = 5'd0;
  logic [4:0]  reg_addr, reg_addr16;
  logic [31:0] reg_data, reg_data16;
  logic [31:0] rd_data, rd_data16;
  logic        rd_changed, rd_changed16;
  logic        busy, busy16, scan_done, scan_done16;

  logic [31:0] regfile [32];

  assign reg_data   = regfile[reg_addr];
  assign reg_data16 = regfile[reg_addr16];

  always #5 clk_in = ~clk_in;

  sm_reg_snapshot dut (
    .clkIn(clk_in), .rst_n(rst_n), .cpuClk(cpu_clk), .freeze(freeze),
    .regAddr(reg_addr), .regData(reg_data), .rdAddr(rd_addr),
    .rdData(rd_data), .rdChanged(rd_changed), .busy(busy), .scanDone(scan_done)
  );

  sm_reg_snapshot #(.NREGS(16)) dut16 (
    .clkIn(clk_in), .rst_n(rst_n), .cpuClk(cpu_clk16), .freeze(freeze),
    .regAddr(reg_addr16), .regData(reg_data16), .rdAddr(rd_addr),
    .rdData(rd_data16), .rdChanged(rd_changed16), .busy(busy16), .scanDone(scan_done16)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chg;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m_snap [32];
  logic        m_chg  [32];
  int          vectors     = 0;
  int          miscompares = 0;

  // Reference model of one complete scan of the 32-register instance.
  task automatic model_scan();
    for (int i = 0; i < 32; i++) begin
      m_chg[i]  = (regfile[i] != m_snap[i]);
      m_snap[i] = regfile[i];
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.addr = 5'(i);
      e.data = m_snap[i];
      e.chg  = m_chg[i];
      sb.push_back(e);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic c,
                    output logic [31:0] d16, output logic c16);
    @(negedge clk_in);
    rd_addr = a;
    @(negedge clk_in);
    d   = rd_data;
    c   = rd_changed;
    d16 = rd_data16;
    c16 = rd_changed16;
  endtask

  // Raises cpu_clk, waits for busy, then counts cycles until scan_done.
  task automatic run_scan(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    @(negedge clk_in);
    cpu_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (busy) break;
    end
    cpu_clk = 1'b0;
    if (busy) begin
      for (int n = 1; n <= 200; n++) begin
        @(negedge clk_in);
        if (scan_done) begin
          lat = n;
          ok  = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #20;
    vectors++;
    if (busy !== 1'b0 || scan_done !== 1'b0 || reg_addr !== 5'd0 ||
        rd_data !== 32'd0 || rd_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b addr=%0d data=%h chg=%b, required all 0",
               busy, scan_done, reg_addr, rd_data, rd_changed);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_single_scan();
    int          lat;
    bit          ok;
    exp_t        e;
    logic [31:0] d, d16;
    logic        c, c16;
    for (int i = 0; i < 32; i++) regfile[i] = 32'hA5A5_0000 + 32'(i);
    model_scan();
    push_expected();
    run_scan(lat, ok);
    vectors++;
    if (!ok || lat != 96) begin
      miscompares++;
      $display("FAIL single_scan_latency: ok=%0d cycles=%0d, required 96", ok, lat);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_scan_busy_at_done: got %b, required 0", busy);
    end
    @(negedge clk_in);
    vectors++;
    if (scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_scan_done_width: got %b, required 0", scan_done);
    end
    vectors++;
    if (reg_addr !== 5'd31) begin
      miscompares++;
      $display("FAIL single_scan_addr_hold: got %0d, required 31", reg_addr);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d, c, d16, c16);
      vectors++;
      if (d !== e.data || c !== e.chg) begin
        miscompares++;
        $display("FAIL single_scan reg %0d: got %h/%b, required %h/%b", e.addr, d, c, e.data, e.chg);
      end
    end
  endtask

  task automatic test_changed_flags();
    int          lat;
    bit          ok;
    exp_t        e;
    logic [31:0] d, d16;
    logic        c, c16;
    regfile[5] = 32'h1234_5678;
    model_scan();
    push_expected();
    run_scan(lat, ok);
    vectors++;
    if (!ok || lat != 96) begin
      miscompares++;
      $display("FAIL changed_latency: ok=%0d cycles=%0d, required 96", ok, lat);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d, c, d16, c16);
      vectors++;
      if (d !== e.data || c !== e.chg) begin
        miscompares++;
        $display("FAIL changed reg %0d: got %h/%b, required %h/%b", e.addr, d, c, e.data, e.chg);
      end
    end
  endtask

  task automatic test_read_before_write();
    logic [31:0] old_d;
    logic        old_c;
    int          hits;
    bit          done_seen;
    old_d = m_snap[20];
    old_c = m_chg[20];
    regfile[20] = 32'h0BAD_F00D;
    model_scan();
    @(negedge clk_in);
    rd_addr = 5'd20;
    cpu_clk = 1'b1;
    hits = 0;
    for (int i = 0; i < 400 && hits < 3; i++) begin
      @(negedge clk_in);
      if (i == 4) cpu_clk = 1'b0;
      if (busy && reg_addr == 5'd20) hits++;
    end
    cpu_clk = 1'b0;
    vectors++;
    if (hits != 3) begin
      miscompares++;
      $display("FAIL rbw_cap_window: saw %0d cycles at idx 20, required 3", hits);
    end
    @(negedge clk_in);
    vectors++;
    if (rd_data !== old_d || rd_changed !== old_c) begin
      miscompares++;
      $display("FAIL rbw_old_value: got %h/%b, required %h/%b", rd_data, rd_changed, old_d, old_c);
    end
    @(negedge clk_in);
    vectors++;
    if (rd_data !== 32'h0BAD_F00D || rd_changed !== 1'b1) begin
      miscompares++;
      $display("FAIL rbw_new_value: got %h/%b, required 0badf00d/1", rd_data, rd_changed);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 300 && !done_seen; i++) begin
      @(negedge clk_in);
      if (scan_done) done_seen = 1'b1;
    end
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("FAIL rbw_scan_done: no scanDone within 300 cycles, required one");
    end
  endtask

  task automatic test_back_to_back();
    int          dones, d1, d2;
    logic        b1, b2;
    bit          seen;
    exp_t        e;
    logic [31:0] d, d16;
    logic        c, c16;
    model_scan();
    model_scan();
    push_expected();
    dones = 0; d1 = -1; d2 = -1; b1 = 1'bx; b2 = 1'bx;
    @(negedge clk_in);
    cpu_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_in);
      if (busy) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL b2b_start: busy not seen within 10 cycles, required 1");
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      case (i)
        3:  cpu_clk = 1'b0;
        10: cpu_clk = 1'b1;
        14: cpu_clk = 1'b0;
        20: cpu_clk = 1'b1;
        24: cpu_clk = 1'b0;
        default: ;
      endcase
      if (scan_done) begin
        dones++;
        if (dones == 1) d1 = i;
        if (dones == 2) d2 = i;
      end
      if (dones >= 1 && i == d1 + 1) b1 = busy;
      if (dones >= 1 && i == d1 + 2) b2 = busy;
    end
    vectors++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d, required 2", dones);
    end
    vectors++;
    if (d1 != 95 || d2 != 193) begin
      miscompares++;
      $display("FAIL b2b_done_timing: got %0d,%0d, required 95,193", d1, d2);
    end
    vectors++;
    if (b1 !== 1'b0 || b2 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: busy after DONE got %b,%b, required 0,1", b1, b2);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d, c, d16, c16);
      vectors++;
      if (d !== e.data || c !== e.chg) begin
        miscompares++;
        $display("FAIL b2b reg %0d: got %h/%b, required %h/%b", e.addr, d, c, e.data, e.chg);
      end
    end
  endtask

  task automatic test_freeze();
    bit          busy_seen;
    int          lat;
    exp_t        e;
    logic [31:0] d, d16;
    logic        c, c16;
    regfile[9] = 32'hDEAD_BEEF;
    model_scan();
    push_expected();
    @(negedge clk_in);
    freeze  = 1'b1;
    cpu_clk = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (i == 4) cpu_clk = 1'b0;
      if (busy) busy_seen = 1'b1;
    end
    vectors++;
    if (busy_seen) begin
      miscompares++;
      $display("FAIL freeze_blocks: busy got 1 while frozen, required 0");
    end
    freeze = 1'b0;
    @(negedge clk_in);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL freeze_release_start: busy got %b, required 1", busy);
    end
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk_in);
      if (n == 30) freeze = 1'b1;
      if (scan_done) begin
        lat = n;
        break;
      end
    end
    freeze = 1'b0;
    vectors++;
    if (lat != 96) begin
      miscompares++;
      $display("FAIL freeze_midscan: scanDone after %0d cycles, required 96", lat);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d, c, d16, c16);
      vectors++;
      if (d !== e.data || c !== e.chg) begin
        miscompares++;
        $display("FAIL freeze reg %0d: got %h/%b, required %h/%b", e.addr, d, c, e.data, e.chg);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit          hit, activity, ok;
    int          lat;
    exp_t        e;
    logic [31:0] d, d16;
    logic        c, c16;
    @(negedge clk_in);
    rd_addr = 5'd3;
    cpu_clk = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk_in);
      if (busy && reg_addr == 5'd10) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rst_mid_reach: idx 10 not reached, required reached");
    end
    vectors++;
    if (rd_data !== m_snap[3]) begin
      miscompares++;
      $display("FAIL rst_mid_preread: got %h, required %h", rd_data, m_snap[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || scan_done !== 1'b0 || reg_addr !== 5'd0 ||
        rd_data !== 32'd0 || rd_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: busy=%b done=%b addr=%0d data=%h chg=%b, required all 0",
               busy, scan_done, reg_addr, rd_data, rd_changed);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (busy || scan_done) activity = 1'b1;
    end
    vectors++;
    if (activity) begin
      miscompares++;
      $display("FAIL rst_mid_no_scan: scan activity after reset with cpuClk held high, required none");
    end
    vectors++;
    if (rd_data !== 32'd0 || rd_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_read3: got %h/%b, required 00000000/0", rd_data, rd_changed);
    end
    cpu_clk = 1'b0;
    repeat (5) @(negedge clk_in);
    for (int i = 0; i < 32; i++) begin
      m_snap[i] = 32'd0;
      m_chg[i]  = 1'b0;
    end
    model_scan();
    push_expected();
    run_scan(lat, ok);
    vectors++;
    if (!ok || lat != 96) begin
      miscompares++;
      $display("FAIL rst_mid_rescan: ok=%0d cycles=%0d, required 96", ok, lat);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd(e.addr, d, c, d16, c16);
      vectors++;
      if (d !== e.data || c !== e.chg) begin
        miscompares++;
        $display("FAIL rst_rescan reg %0d: got %h/%b, required %h/%b", e.addr, d, c, e.data, e.chg);
      end
    end
  endtask

  task automatic test_nregs16();
    int          lat;
    bit          seen;
    logic [31:0] d, d16;
    logic        c, c16;
    @(negedge clk_in);
    cpu_clk16 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_in);
      if (busy16) seen = 1'b1;
    end
    cpu_clk16 = 1'b0;
    lat = 0;
    if (seen) begin
      for (int n = 1; n <= 200; n++) begin
        @(negedge clk_in);
        if (scan_done16) begin
          lat = n;
          break;
        end
      end
    end
    vectors++;
    if (lat != 48) begin
      miscompares++;
      $display("FAIL n16_latency: got %0d cycles, required 48", lat);
    end
    rd(5'd7, d, c, d16, c16);
    vectors++;
    if (d16 !== regfile[7] || c16 !== 1'b1) begin
      miscompares++;
      $display("FAIL n16_reg7: got %h/%b, required %h/1", d16, c16, regfile[7]);
    end
    rd(5'd15, d, c, d16, c16);
    vectors++;
    if (d16 !== regfile[15] || c16 !== 1'b1) begin
      miscompares++;
      $display("FAIL n16_reg15: got %h/%b, required %h/1", d16, c16, regfile[15]);
    end
    rd(5'd31, d, c, d16, c16);
    vectors++;
    if (d16 !== 32'd0 || c16 !== 1'b0) begin
      miscompares++;
      $display("FAIL n16_out_of_range: got %h/%b, required 00000000/0", d16, c16);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regfile[i] = 32'd0;
      m_snap[i]  = 32'd0;
      m_chg[i]   = 1'b0;
    end
    test_reset();
    test_single_scan();
    test_changed_flags();
    test_read_before_write();
    test_back_to_back();
    test_freeze();
    test_reset_mid_scan();
    test_nregs16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sm_reg_snapshot.md
SM_REG_SNAPSHOT -- requirements
Module: sm_reg_snapshot

Interface
REQ-001 Parameter NREGS, default 32, number of CPU registers scanned (power of two, 2..32).
REQ-002 Parameter SETTLE, default 2, clkIn cycles regAddr is held before capture (>=1).
REQ-003 clkIn  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cpuClk  input  1  divided CPU clock, asynchronous to clkIn; each rising edge requests a scan.
REQ-006 freeze  input  1  when high, no new scan starts; requests stay pending.
REQ-007 regAddr  output  5  register-file debug read address driven to the CPU.
REQ-008 regData  input  32  register-file debug read data, valid SETTLE cycles after regAddr changes.
REQ-009 rdAddr  input  5  display-side read address.
REQ-010 rdData  output  32  snapshot word at rdAddr, registered.
REQ-011 rdChanged  output  1  change flag of register rdAddr, registered with rdData.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 scanDone  output  1  one-cycle pulse when a scan completes.

Function
REQ-014 cpuClk SHALL pass a 2-flop synchronizer, then a delay flop; edge = sync2 & ~delay.
REQ-015 FSM states SHALL be IDLE, ADDR, CAP, DONE.
REQ-016 pending flag SHALL be set by edge in any state and cleared when a scan starts.
REQ-017 IDLE -> ADDR when (edge | pending) & ~freeze; idx <= 0, pending <= 0, busy <= 1.
REQ-018 ADDR SHALL drive regAddr = idx and hold for SETTLE cycles (settle counter), then go to CAP.
REQ-019 CAP (one cycle) SHALL write snap[idx] <= regData and changed[idx] <= (regData != snap[idx]).
REQ-020 CAP -> ADDR with idx+1 if idx < NREGS-1; else CAP -> DONE.
REQ-021 DONE SHALL assert scanDone for one cycle, drop busy, go to IDLE; IDLE restarts next cycle if pending & ~freeze.
REQ-022 Scan time SHALL be exactly NREGS*(SETTLE+1) cycles from leaving IDLE to entering DONE.
REQ-023 Multiple edges during one scan SHALL collapse into a single pending request.
REQ-024 freeze SHALL NOT abort a scan in progress; it only blocks IDLE -> ADDR.
REQ-025 regAddr SHALL hold its last value in IDLE and DONE.
REQ-026 rdData/rdChanged SHALL equal snap[rdAddr]/changed[rdAddr] one cycle after rdAddr is applied; rdAddr >= NREGS returns 0/0.
REQ-027 Same-cycle CAP write and read of the same index SHALL return the old value (read-before-write).
REQ-028 changed flags SHALL be recomputed every scan (cleared when value is unchanged).

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, idx 0, regAddr 0, pending 0, sync flops 0, busy 0, scanDone 0, rdData 0, rdChanged 0, all snap words 0, all changed flags 0.
REQ-030 Reset mid-scan SHALL discard the partial scan; no scanDone pulse is emitted.
REQ-031 After rst_n rises, the first scan SHALL start only on a cpuClk rising edge seen after reset; a cpuClk level already high is not an edge.

Verification
REQ-032 Single edge, freeze=0, regData=0xA5A50000+regAddr -> busy high; scanDone 64*... no: scanDone after 32*3=96 cycles; snap[7]=0xA5A50007; all changed=1.
REQ-033 Second scan with only reg 5 altered to 0x12345678 -> rdAddr=5 gives 0x12345678/changed=1; rdAddr=6 gives changed=0.
REQ-034 Three cpuClk edges during one scan -> exactly two scanDone pulses total, second scan starts one cycle after DONE.
REQ-035 freeze=1 then edge -> busy stays 0; freeze drops -> scan starts next cycle; freeze raised mid-scan -> scan completes.
REQ-036 rst_n pulsed low at idx=10 -> all outputs 0 immediately, no scanDone, rdAddr=3 reads 0 after release.
REQ-037 rdAddr=31 with NREGS=16 -> rdData=0, rdChanged=0.
